// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : timer_sequencer
// Description : Drives an interval-timer slave over a simple address/chip-
//               select bus. Programs the period and starts the timer,
//               services timeout interrupts (tick), captures snapshots of the
//               live counter and stops the timer on request.
// Ports       : clk, reset_n         - clock, async active-low reset
//               cfg_start/stop/snap  - one-cycle command pulses
//               cfg_period[31:0]     - period minus 1 (0 selects default)
//               tmr_*                - timer slave bus (outputs registered)
//               tick, tick_count     - timeout pulse and wrapping counter
//               snap_value/valid     - captured counter value and pulse
//               running, busy        - state-decoded status
// Revision    : 1.0 - initial release
// ============================================================================
module timer_sequencer #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd79999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        cfg_snap,
    input  logic [31:0] cfg_period,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    output logic        running,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PL    = 4'd1,
        ST_PH    = 4'd2,
        ST_CTRL  = 4'd3,
        ST_RUN   = 4'd4,
        ST_CLR   = 4'd5,
        ST_SNAPW = 4'd6,
        ST_RDL   = 4'd7,
        ST_RDH   = 4'd8,
        ST_RDW   = 4'd9,
        ST_STOP  = 4'd10
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] period_q,      period_d;
    logic [31:0] pend_period_q, pend_period_d;
    logic        start_pend_q,  start_pend_d;
    logic        stop_pend_q,   stop_pend_d;
    logic        snap_pend_q,   snap_pend_d;
    logic        tick_q,        tick_d;
    logic [15:0] tick_count_q,  tick_count_d;
    logic [31:0] snap_value_q,  snap_value_d;
    logic        snap_valid_q,  snap_valid_d;
    logic [2:0]  addr_q,        addr_d;
    logic        cs_q,          cs_d;
    logic        wn_q,          wn_d;
    logic [15:0] wd_q,          wd_d;

    // A zero period request selects the default period.
    function automatic logic [31:0] sel_period(input logic [31:0] p);
        return (p == 32'd0) ? DEFAULT_PERIOD : p;
    endfunction

    wire w_busy = (state_q != ST_IDLE) && (state_q != ST_RUN);

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        pend_period_d = pend_period_q;
        start_pend_d  = start_pend_q;
        stop_pend_d   = stop_pend_q;
        snap_pend_d   = snap_pend_q;
        tick_d        = 1'b0;
        snap_valid_d  = 1'b0;
        tick_count_d  = tick_count_q;
        snap_value_d  = snap_value_q;

        case (state_q)
            ST_IDLE: begin
                // Stop and snap requests mean nothing without a running timer.
                stop_pend_d = 1'b0;
                snap_pend_d = 1'b0;
                if (cfg_start || start_pend_q) begin
                    period_d     = cfg_start ? sel_period(cfg_period) : pend_period_q;
                    start_pend_d = 1'b0;
                    tick_count_d = 16'd0;
                    state_d      = ST_PL;
                end
            end
            ST_PL:    state_d = ST_PH;
            ST_PH:    state_d = ST_CTRL;
            ST_CTRL:  state_d = ST_RUN;
            ST_CLR:   state_d = ST_RUN;
            ST_SNAPW: state_d = ST_RDL;
            ST_RDL:   state_d = ST_RDH;
            ST_RDH: begin
                // Read data for address 4 arrives one cycle after RDL.
                snap_value_d[15:0] = tmr_readdata;
                state_d            = ST_RDW;
            end
            ST_RDW: begin
                snap_value_d[31:16] = tmr_readdata;
                snap_valid_d        = 1'b1;
                state_d             = ST_RUN;
            end
            ST_STOP:  state_d = ST_IDLE;
            ST_RUN: begin
                // One event per cycle; fresh pulses that lose arbitration
                // are parked in the pending flags.
                if (tmr_irq) begin
                    state_d      = ST_CLR;
                    tick_d       = 1'b1;
                    tick_count_d = tick_count_q + 16'd1;
                    if (cfg_start) begin
                        start_pend_d  = 1'b1;
                        pend_period_d = sel_period(cfg_period);
                    end
                    if (cfg_stop) stop_pend_d = 1'b1;
                    if (cfg_snap) snap_pend_d = 1'b1;
                end else if (cfg_start || start_pend_q) begin
                    period_d     = cfg_start ? sel_period(cfg_period) : pend_period_q;
                    start_pend_d = 1'b0;
                    tick_count_d = 16'd0;
                    state_d      = ST_PL;
                    if (cfg_stop) stop_pend_d = 1'b1;
                    if (cfg_snap) snap_pend_d = 1'b1;
                end else if (cfg_stop || stop_pend_q) begin
                    stop_pend_d = 1'b0;
                    state_d     = ST_STOP;
                    if (cfg_snap) snap_pend_d = 1'b1;
                end else if (cfg_snap || snap_pend_q) begin
                    snap_pend_d = 1'b0;
                    state_d     = ST_SNAPW;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Commands arriving during a bus sequence wait for the next RUN cycle.
        if (w_busy) begin
            if (cfg_stop) stop_pend_d = 1'b1;
            if (cfg_snap) snap_pend_d = 1'b1;
            if (cfg_start) begin
                start_pend_d  = 1'b1;
                pend_period_d = sel_period(cfg_period);
                stop_pend_d   = 1'b0;
                snap_pend_d   = 1'b0;
            end
        end
    end

    // Bus outputs are decoded from the next state and registered, so they
    // line up exactly with the state they belong to.
    always_comb begin
        addr_d = 3'd0;
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        wd_d   = 16'h0000;
        case (state_d)
            ST_PL:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_d[15:0];  end
            ST_PH:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_d[31:16]; end
            ST_CTRL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0007;        end
            ST_CLR:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wd_d = 16'h0000;        end
            ST_SNAPW: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; wd_d = 16'h0000;        end
            ST_RDL:   begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd4;                         end
            ST_RDH:   begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd5;                         end
            ST_STOP:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008;        end
            default:  begin cs_d = 1'b0; wn_d = 1'b1; addr_d = 3'd0; wd_d = 16'h0000;        end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            period_q      <= 32'd0;
            pend_period_q <= 32'd0;
            start_pend_q  <= 1'b0;
            stop_pend_q   <= 1'b0;
            snap_pend_q   <= 1'b0;
            tick_q        <= 1'b0;
            tick_count_q  <= 16'd0;
            snap_value_q  <= 32'd0;
            snap_valid_q  <= 1'b0;
            addr_q        <= 3'd0;
            cs_q          <= 1'b0;
            wn_q          <= 1'b1;
            wd_q          <= 16'h0000;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            pend_period_q <= pend_period_d;
            start_pend_q  <= start_pend_d;
            stop_pend_q   <= stop_pend_d;
            snap_pend_q   <= snap_pend_d;
            tick_q        <= tick_d;
            tick_count_q  <= tick_count_d;
            snap_value_q  <= snap_value_d;
            snap_valid_q  <= snap_valid_d;
            addr_q        <= addr_d;
            cs_q          <= cs_d;
            wn_q          <= wn_d;
            wd_q          <= wd_d;
        end
    end

    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wd_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign snap_value     = snap_value_q;
    assign snap_valid     = snap_valid_q;
    assign running        = (state_q == ST_RUN)   || (state_q == ST_CLR) ||
                            (state_q == ST_SNAPW) || (state_q == ST_RDL) ||
                            (state_q == ST_RDH)   || (state_q == ST_RDW);
    assign busy           = w_busy;

endmodule
`default_nettype wire
